// File: rtl/mem_access_sequencer_pkg.sv
// Shared state codes and default parameters for the M1->M2 data-memory sequencer.
// The optional access timeout is enabled by defining MEM_TIMEOUT_EN.
package mem_access_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT_CYC = 16;
    localparam int DEF_CNT_W       = 5;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bundles the M1 request side, the data-memory req/ready bus and the pipeline-buffer controls.
// Handshake: dmem_req stays high with stable we/addr/wdata until a cycle where dmem_ready=1; rdata is valid in that cycle.
interface mem_access_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req_m1;
    logic          mem_we_m1;
    logic [AW-1:0] addr_m1;
    logic [DW-1:0] wdata_m1;
    logic          flush;

    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ready;
    logic [DW-1:0] dmem_rdata;

    logic          stall;
    logic          buf_en;
    logic          buf_bubble;
    logic [DW-1:0] rdata_m2;
    logic          err;
    logic [1:0]    state;

    modport master (
        input  mem_req_m1, mem_we_m1, addr_m1, wdata_m1, flush,
        input  dmem_ready, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output stall, buf_en, buf_bubble, rdata_m2, err, state
    );

    modport slave (
        output mem_req_m1, mem_we_m1, addr_m1, wdata_m1, flush,
        output dmem_ready, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  stall, buf_en, buf_bubble, rdata_m2, err, state
    );

endinterface

// File: rtl/mem_access_sequencer_timer.sv
// Wait-cycle counter for an outstanding data-memory access; hit flags the last allowed cycle.
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (!RSTN || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences M1 loads/stores onto the data-memory bus, stalls the pipeline while waiting and
// drives the M1->M2 buffer enable/bubble. Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYC cycles.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic                   CLK,
    input logic                   RSTN,
    mem_access_sequencer_if.master bus
);

    state_t state;
    logic   kill;
    logic   hit;
    logic   accept;

    assign accept = bus.mem_req_m1 && !bus.flush;

    mem_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) u_timer (
        .CLK (CLK),
        .RSTN(RSTN),
        .clr (state == ST_DONE),
        .inc (state == ST_ACCESS),
        .hit (hit)
    );

`ifdef MEM_TIMEOUT_EN
    logic err_q;
    assign bus.err = err_q;
`else
    logic timer_hit_unused;
    assign timer_hit_unused = hit;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state          <= ST_IDLE;
            kill           <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.rdata_m2   <= '0;
`ifdef MEM_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= bus.mem_we_m1;
                        bus.dmem_addr  <= bus.addr_m1;
                        bus.dmem_wdata <= bus.wdata_m1;
                        state          <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A flushed access is still finished; it simply retires as a bubble.
                    if (bus.dmem_ready) begin
                        bus.dmem_req <= 1'b0;
                        if (!bus.dmem_we) begin
                            bus.rdata_m2 <= bus.dmem_rdata;
                        end
                        if (bus.flush) begin
                            kill <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (hit) begin
                        bus.dmem_req <= 1'b0;
                        err_q        <= 1'b1;
                        kill         <= 1'b1;
                        state        <= ST_DONE;
                    end
`endif
                    else if (bus.flush) begin
                        kill <= 1'b1;
                    end
                end
                ST_DONE: begin
                    kill  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // IDLE decode is combinational so ALU ops pass with no added latency.
    always_comb begin
        bus.stall      = 1'b0;
        bus.buf_en     = 1'b0;
        bus.buf_bubble = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.stall      = accept;
                bus.buf_en     = !accept;
                bus.buf_bubble = bus.flush;
            end
            ST_ACCESS: begin
                bus.stall = 1'b1;
            end
            ST_DONE: begin
                bus.buf_en     = 1'b1;
                bus.buf_bubble = kill;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

    assign bus.state = state;

endmodule
